branch_predictor: RTL and testbench

Parametrised successor to the single-cycle control-transfer decision. It keeps a direction predictor (branch history table of 2-bit saturating counters) for the fetch stage and resolves branches, JAL and JALR in the execute stage against the prediction made for them. It reports redirects with the existing `CTL_PC_*` select encoding, trains the table, and keeps saturating branch and mispredict counters. It sits between fetch (lookup port) and execute (resolve port) of the pipelined core.

---
 rtl/branch_predictor.sv | 163 ++++++++++++++++
 tb/tb_branch_predictor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BHT direction predictor with execute-stage resolution,
// table training, sequential flush and saturating performance counters.
module branch_predictor #(
   parameter int         BHT_ENTRIES  = 64,
   parameter logic [1:0] COUNTER_INIT = 2'b01,
   parameter int         COUNT_WIDTH  = 32
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   fetch_valid_i,
   input  logic [31:0]            fetch_pc_i,
   output logic                   predict_taken_o,
   input  logic                   ex_valid_i,
   input  logic [31:0]            ex_pc_i,
   input  logic                   ex_predicted_taken_i,
   input  logic                   branch_enable_i,
   input  logic                   jal_enable_i,
   input  logic                   jalr_enable_i,
   input  logic                   result_equal_zero_i,
   input  logic [2:0]             inst_funct3_i,
   input  logic                   bht_flush_i,
   output logic                   redirect_o,
   output logic [1:0]             next_pc_select_o,
   output logic                   flush_busy_o,
   output logic [COUNT_WIDTH-1:0] branch_count_o,
   output logic [COUNT_WIDTH-1:0] mispredict_count_o
);

   localparam int IDX = $clog2(BHT_ENTRIES);

   localparam logic [1:0] CTL_PC_PC4     = 2'b00;
   localparam logic [1:0] CTL_PC_PC_IMM  = 2'b01;
   localparam logic [1:0] CTL_PC_RS1_IMM = 2'b10;

   typedef enum logic {IDLE, CLEAR} state_e;

   state_e                 state_q;
   logic [IDX-1:0]         ptr_q;
   logic                   flush_busy_q;
   logic [1:0]             bht_q [BHT_ENTRIES];
   logic [COUNT_WIDTH-1:0] branch_count_q, branch_count_d;
   logic [COUNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;
   logic [1:0]             ex_ctr_d;

   logic [IDX-1:0] fetch_idx, ex_idx;
   logic           br_is_cond, br_taken_on_zero, br_taken;
   logic           br_valid, br_redirect, train_en;
   logic           unused_pc_bits;

   assign fetch_idx = fetch_pc_i[IDX+1:2];
   assign ex_idx    = ex_pc_i[IDX+1:2];
   assign unused_pc_bits = ^{fetch_pc_i[31:IDX+2], fetch_pc_i[1:0],
                             ex_pc_i[31:IDX+2], ex_pc_i[1:0]};

   // funct3 010/011 are not conditional branches at all
   assign br_is_cond       = inst_funct3_i[2:1] != 2'b01;
   assign br_taken_on_zero = (inst_funct3_i == 3'b000) || (inst_funct3_i == 3'b101) ||
                             (inst_funct3_i == 3'b111);
   assign br_taken    = br_is_cond & (br_taken_on_zero ? result_equal_zero_i : ~result_equal_zero_i);
   assign br_valid    = ex_valid_i & branch_enable_i & br_is_cond;
   assign br_redirect = br_valid & (br_taken ^ ex_predicted_taken_i);
   assign train_en    = br_valid & ~flush_busy_q;

   assign predict_taken_o = fetch_valid_i & ~flush_busy_q & bht_q[fetch_idx][1];

   always_comb begin
      redirect_o       = 1'b0;
      next_pc_select_o = CTL_PC_PC4;
      if (ex_valid_i) begin
         if (branch_enable_i) begin
            redirect_o       = br_redirect;
            next_pc_select_o = br_taken ? CTL_PC_PC_IMM : CTL_PC_PC4;
         end else if (jal_enable_i) begin
            redirect_o       = 1'b1;
            next_pc_select_o = CTL_PC_PC_IMM;
         end else if (jalr_enable_i) begin
            redirect_o       = 1'b1;
            next_pc_select_o = CTL_PC_RS1_IMM;
         end
      end
   end

   always_comb begin
      ex_ctr_d = bht_q[ex_idx];
      if (br_taken && bht_q[ex_idx] != 2'b11) begin
         ex_ctr_d = bht_q[ex_idx] + 2'd1;
      end else if (!br_taken && bht_q[ex_idx] != 2'b00) begin
         ex_ctr_d = bht_q[ex_idx] - 2'd1;
      end
   end

   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (br_valid && branch_count_q != '1) begin
         branch_count_d = branch_count_q + COUNT_WIDTH'(1);
      end
      if (br_redirect && mispredict_count_q != '1) begin
         mispredict_count_d = mispredict_count_q + COUNT_WIDTH'(1);
      end
   end

   // A flush request in CLEAR restarts the sweep from entry 0
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         flush_busy_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bht_flush_i) begin
                  state_q      <= CLEAR;
                  ptr_q        <= '0;
                  flush_busy_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (bht_flush_i) begin
                  ptr_q <= '0;
               end else if (ptr_q == '1) begin
                  state_q      <= IDLE;
                  ptr_q        <= '0;
                  flush_busy_q <= 1'b0;
               end else begin
                  ptr_q <= ptr_q + IDX'(1);
               end
            end
            default: begin
               state_q      <= IDLE;
               flush_busy_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= COUNTER_INIT;
         end
      end else if (flush_busy_q) begin
         bht_q[ptr_q] <= COUNTER_INIT;
      end else if (train_en) begin
         bht_q[ex_idx] <= ex_ctr_d;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign flush_busy_o       = flush_busy_q;
   assign branch_count_o     = branch_count_q;
   assign mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor.
module tb_branch_predictor;

   localparam int N    = 64;
   localparam int CW   = 6;
   localparam int MAXC = (1 << CW) - 1;
   localparam logic [1:0] PC4 = 2'b00, IMM = 2'b01, RS1 = 2'b10;

   logic          clk = 1'b0, rst = 1'b1;
   logic          fetch_valid, ex_valid, ex_pred, br_en, jal_en, jalr_en, zero, bht_flush;
   logic [31:0]   fetch_pc, ex_pc;
   logic [2:0]    funct3;
   logic          predict_taken, redirect, flush_busy;
   logic [1:0]    next_pc_select;
   logic [CW-1:0] branch_count, mispredict_count;

   branch_predictor #(.BHT_ENTRIES(N), .COUNTER_INIT(2'b01), .COUNT_WIDTH(CW)) dut (
      .clock_i(clk), .reset_i(rst),
      .fetch_valid_i(fetch_valid), .fetch_pc_i(fetch_pc), .predict_taken_o(predict_taken),
      .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .ex_predicted_taken_i(ex_pred),
      .branch_enable_i(br_en), .jal_enable_i(jal_en), .jalr_enable_i(jalr_en),
      .result_equal_zero_i(zero), .inst_funct3_i(funct3), .bht_flush_i(bht_flush),
      .redirect_o(redirect), .next_pc_select_o(next_pc_select), .flush_busy_o(flush_busy),
      .branch_count_o(branch_count), .mispredict_count_o(mispredict_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_fail = 0;
   bit run_cmp = 0;

   // Reference model: table contents, remaining clear cycles, counters
   int mb[N];
   int rem, bc, mc;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic bit is_cond(input logic [2:0] f3);
      return (f3 != 3'd2) && (f3 != 3'd3);
   endfunction

   function automatic bit taken_of(input logic [2:0] f3, input logic z);
      case (f3)
         3'd0, 3'd5, 3'd7: return z;
         3'd1, 3'd4, 3'd6: return !z;
         default:          return 1'b0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) mb[i] = 1;
         rem = 0; bc = 0; mc = 0;
      end else begin
         if (ex_valid && br_en && is_cond(funct3)) begin
            if (bc < MAXC) bc++;
            if ((taken_of(funct3, zero) != ex_pred) && mc < MAXC) mc++;
            if (rem == 0) begin
               if (taken_of(funct3, zero)) mb[idx_of(ex_pc)] = (mb[idx_of(ex_pc)] < 3) ? mb[idx_of(ex_pc)] + 1 : 3;
               else                        mb[idx_of(ex_pc)] = (mb[idx_of(ex_pc)] > 0) ? mb[idx_of(ex_pc)] - 1 : 0;
            end
         end
         if (bht_flush) begin
            rem = N;
            for (int i = 0; i < N; i++) mb[i] = 1;
         end else if (rem > 0) begin
            rem--;
         end
      end
   end

   always @(negedge clk) begin
      if (run_cmp && !rst) begin
         logic       e_red;
         logic [1:0] e_sel;
         e_red = 1'b0; e_sel = PC4;
         if (ex_valid) begin
            if (br_en) begin
               if (is_cond(funct3)) begin
                  e_red = taken_of(funct3, zero) ^ ex_pred;
                  e_sel = taken_of(funct3, zero) ? IMM : PC4;
               end
            end else if (jal_en) begin
               e_red = 1'b1; e_sel = IMM;
            end else if (jalr_en) begin
               e_red = 1'b1; e_sel = RS1;
            end
         end
         check("model_predict", predict_taken, fetch_valid && rem == 0 && mb[idx_of(fetch_pc)] >= 2);
         check("model_redirect", redirect, e_red);
         check("model_select", next_pc_select, e_sel);
         check("model_flush_busy", flush_busy, rem > 0);
         check("model_branch_count", branch_count, bc);
         check("model_mispredict_count", mispredict_count, mc);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_in();
      fetch_valid = 0; fetch_pc = 0; ex_valid = 0; ex_pc = 0; ex_pred = 0;
      br_en = 0; jal_en = 0; jalr_en = 0; zero = 0; funct3 = 0; bht_flush = 0;
   endtask

   task automatic set_br(input logic [31:0] pc, input logic [2:0] f3, input logic z, input logic p);
      ex_valid = 1; br_en = 1; jal_en = 0; jalr_en = 0;
      ex_pc = pc; funct3 = f3; zero = z; ex_pred = p;
   endtask

   task automatic do_reset();
      rst = 1; idle_in(); tick(); tick(); rst = 0; tick();
   endtask

   task automatic train_taken(input logic [31:0] pc, input int times);
      for (int i = 0; i < times; i++) begin
         set_br(pc, 3'd0, 1'b1, 1'b1); tick();
      end
      idle_in();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cycles;
      logic pred_or;
      idle_in();
      do_reset();
      run_cmp = 1;

      fetch_valid = 1; fetch_pc = 32'h100; #1;
      check("reset_predict", predict_taken, 0);
      check("reset_branch_count", branch_count, 0);
      check("reset_mispredict_count", mispredict_count, 0);
      check("reset_flush_busy", flush_busy, 0);

      set_br(32'h100, 3'd0, 1'b1, 1'b0); #1;
      check("beq1_redirect", redirect, 1);
      check("beq1_select", next_pc_select, IMM);
      tick();
      set_br(32'h100, 3'd0, 1'b1, 1'b0); #1;
      check("beq2_redirect", redirect, 1);
      tick(); #1;
      check("lookup_after_train", predict_taken, 1);
      set_br(32'h100, 3'd0, 1'b1, 1'b1); #1;
      check("beq3_redirect", redirect, 0);
      tick();
      check("beq_branch_count", branch_count, 3);
      check("beq_mispredict_count", mispredict_count, 2);

      set_br(32'h100, 3'd1, 1'b1, 1'b1); #1;
      check("bne_redirect", redirect, 1);
      check("bne_select", next_pc_select, PC4);
      tick(); #1;
      check("bne_dec_lookup", predict_taken, 1);
      set_br(32'h100, 3'd1, 1'b1, 1'b1); tick(); #1;
      check("bne_dec2_lookup", predict_taken, 0);

      br_en = 0; jalr_en = 1; #1;
      check("jalr_redirect", redirect, 1);
      check("jalr_select", next_pc_select, RS1);
      tick();

      set_br(32'h100, 3'd2, 1'b1, 1'b0); #1;
      check("f3_010_redirect", redirect, 0);
      check("f3_010_select", next_pc_select, PC4);
      tick();
      check("f3_010_branch_count", branch_count, 5);
      check("f3_010_mispredict_count", mispredict_count, 4);
      set_br(32'h100, 3'd0, 1'b1, 1'b0); tick(); #1;
      check("f3_010_table_kept", predict_taken, 1);

      set_br(32'h200, 3'd0, 1'b0, 1'b0); jal_en = 1; #1;
      check("prio_branch_over_jal_redirect", redirect, 0);
      check("prio_branch_over_jal_select", next_pc_select, PC4);
      tick();
      idle_in(); ex_valid = 1; jal_en = 1; jalr_en = 1; #1;
      check("prio_jal_over_jalr_select", next_pc_select, IMM);
      tick();

      idle_in();
      train_taken(32'h0, 2); train_taken(32'h4, 2); train_taken(32'h8, 2);
      fetch_valid = 1; fetch_pc = 32'h4; #1;
      check("pre_flush_predict", predict_taken, 1);
      bht_flush = 1; tick(); bht_flush = 0;
      busy_cycles = 0; pred_or = 0;
      for (int c = 0; c < 200; c++) begin
         if (!flush_busy) break;
         busy_cycles++;
         pred_or |= predict_taken;
         tick();
      end
      check("flush_busy_cycles", busy_cycles, N);
      check("flush_predict_low", pred_or, 0);
      for (int k = 0; k < 3; k++) begin
         fetch_pc = 32'(k * 4); #1;
         check("post_flush_predict", predict_taken, 0);
      end
      train_taken(32'h4, 1);
      fetch_valid = 1; fetch_pc = 32'h4; #1;
      check("post_flush_entry_init", predict_taken, 1);

      train_taken(32'h8, 2);
      bht_flush = 1; tick(); bht_flush = 0;
      repeat (19) tick();
      rst = 1; #1;
      check("reset_abort_busy", flush_busy, 0);
      check("reset_abort_count", branch_count, 0);
      tick(); rst = 0; tick();
      fetch_valid = 1; fetch_pc = 32'h8; #1;
      check("reset_abort_idle", flush_busy, 0);
      check("reset_abort_entry", predict_taken, 0);
      train_taken(32'h8, 1);
      fetch_valid = 1; fetch_pc = 32'h8; #1;
      check("reset_abort_entry_init", predict_taken, 1);

      do_reset();
      for (int i = 0; i < MAXC; i++) begin
         set_br(32'h300, 3'd0, 1'b1, 1'b0); tick();
      end
      check("mispredict_at_max", mispredict_count, MAXC);
      for (int i = 0; i < 5; i++) begin
         set_br(32'h300, 3'd0, 1'b1, 1'b0); tick();
      end
      check("mispredict_saturated", mispredict_count, MAXC);
      check("branch_saturated", branch_count, MAXC);

      do_reset();
      for (int i = 0; i < 1500; i++) begin
         int cls;
         fetch_valid = $urandom_range(0, 3) != 0;
         fetch_pc    = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
         ex_valid    = $urandom_range(0, 3) != 0;
         ex_pc       = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
         funct3      = 3'($urandom_range(0, 7));
         zero        = 1'($urandom_range(0, 1));
         ex_pred     = 1'($urandom_range(0, 1));
         bht_flush   = $urandom_range(0, 99) == 0;
         cls         = $urandom_range(0, 9);
         br_en       = cls <= 5;
         jal_en      = cls == 6 || cls == 9;
         jalr_en     = cls == 7 || cls == 9;
         tick();
      end
      idle_in();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
